rob_multi_wb: RTL and testbench
===============================

Name: rob_multi_wb

Overview:
- Parametrised reorder buffer: next generation of the core's in-order-commit queue.
- Adds configurable depth, N writeback channels, an explicit occupancy count, branch-prediction verification with redirect, and a store-commit handshake with the LSB.
- Sits between issue (allocation), ALU/LSB result buses (writeback) and the regfile/fetch (commit, flush).

Parameters:
- DEPTH, 32, entry count; power of 2, >=4
- IDX_W, 5, log2(DEPTH); tag width
- XLEN, 32, data/pc width
- REG_W, 5, architectural register index width
- WB_CH, 2, number of writeback channels
- FULL_MARGIN, 1, free entries still held when `full` asserts

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset; asynchronous, active-low
- rdy_in  in  1  global enable; when low all state holds
- issue_valid  in  1  allocate request
- issue_kind  in  2  0=REG, 1=BRANCH, 2=JALR, 3=STORE
- issue_pc  in  XLEN  instruction pc
- issue_imm  in  XLEN  branch offset
- issue_rd  in  REG_W  destination register (0 = none)
- issue_pred_taken  in  1  fetch's branch prediction
- issue_tag  out  IDX_W  tag allocated if issue accepted (= tail)
- full  out  1  count >= DEPTH-FULL_MARGIN
- count  out  IDX_W+1  occupied entries
- head_tag  out  IDX_W  oldest entry
- wb_valid  in  WB_CH  per-channel result strobe
- wb_tag  in  WB_CH*IDX_W  packed tags, channel 0 in LSBs
- wb_val  in  WB_CH*XLEN  packed results (JALR: target address)
- wb_taken  in  WB_CH  branch outcome
- commit_valid  out  1  registered one-cycle pulse: register write
- commit_tag  out  IDX_W  tag of committing entry
- commit_rd  out  REG_W  destination
- commit_val  out  XLEN  value
- store_req  out  1  head is a STORE awaiting memory commit
- store_tag  out  IDX_W  tag of that store
- store_ack  in  1  LSB has performed the store
- flush  out  1  registered one-cycle pulse: squash all younger work
- redirect_pc  out  XLEN  fetch target, valid with flush

Behaviour:
- Reset: head=tail=count=0; all entries not-valid/not-ready; every output 0.
- rdy_in=0: no state change; commit_valid and flush forced 0 on the next edge.
- Issue:
  - Accepted iff issue_valid && !full.
  - Entry written at tail: valid=1; ready=(kind==STORE); fields stored.
  - tail = (tail+1) mod DEPTH, wrapping naturally via IDX_W bits.
  - issue_valid while full is dropped; issue must hold.
- Writeback:
  - Each channel with wb_valid whose tag hits a valid entry sets ready and stores val/taken.
  - Writeback to an invalid tag is ignored.
  - Two channels with the same tag in one cycle: lowest channel index wins.
  - Ready becomes visible to commit one cycle after writeback; no same-cycle bypass.
- Commit: at most one per cycle, only when the head entry is valid and ready.
  - REG: commit_valid=1, commit_rd/val/tag from entry; rd=0 still pulses with commit_rd=0.
  - BRANCH: no register write.
    - If taken != pred_taken: flush=1; redirect_pc = taken ? pc+imm : pc+4 (mod 2^XLEN).
    - Otherwise retires silently.
  - JALR: commit_valid=1, commit_val=pc+4; flush=1; redirect_pc = val with bit 0 cleared.
  - STORE:
    - store_req=1 combinationally while the head is a STORE.
    - Retires with no commit_valid on the edge where store_ack=1.
    - store_ack without store_req is ignored.
- count: +1 on accepted issue, -1 on retire; both in one cycle leave it unchanged. full/count are registered from post-edge state.
- Flush:
  - The edge that registers flush=1 also clears head, tail, count and all valid bits.
  - Any issue or writeback in that cycle is discarded.
  - flush deasserts the following cycle; issue is accepted again that same cycle.
- Empty (count=0): no commit, store_req=0.
- Full with simultaneous retire: issue still refused that cycle, because full is registered.
- Asynchronous reset mid-operation: immediate return to the reset state, including a pending store_req and any in-flight flush.

Test Plan:
- Issue 3 REG (rd=1,2,3); write back tags 2,0,1 on ch1/ch0 in separate cycles -> commits in order 0,1,2 with correct vals, each ≥1 cycle after its writeback; count returns to 0.
- DEPTH=8, FULL_MARGIN=1: issue 7 -> full=1, count=7; 8th issue_valid dropped; retire 1 -> full=0 next cycle; tags wrap 7->0 correctly.
- BRANCH pc=0x100, imm=0x20, pred=0, wb_taken=1 -> flush pulse, redirect_pc=0x120, count=0 next cycle; repeat with pred=1, taken=1 -> no flush.
- JALR pc=0x200, wb_val=0x305 -> commit_val=0x204, redirect_pc=0x304, flush=1.
- STORE at head: store_req=1 held for 3 cycles without ack; head stalls; store_ack on cycle 4 -> retires, next REG commits.
- Both channels write the same tag (vals 0xA, 0xB) -> committed value 0xA; rst_n_in pulsed low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/rob_multi_wb_if.sv
// Bundle of the reorder buffer's issue, writeback, commit, store and flush signals.
// master = the surrounding core, slave = the reorder buffer.
interface rob_multi_wb_if #(
  parameter int unsigned IDX_W = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 5,
  parameter int unsigned WB_CH = 2
);
  logic                   issue_valid;
  logic [1:0]             issue_kind;
  logic [XLEN-1:0]        issue_pc;
  logic [XLEN-1:0]        issue_imm;
  logic [REG_W-1:0]       issue_rd;
  logic                   issue_pred_taken;
  logic [IDX_W-1:0]       issue_tag;
  logic                   full;
  logic [IDX_W:0]         count;
  logic [IDX_W-1:0]       head_tag;

  logic [WB_CH-1:0]       wb_valid;
  logic [WB_CH*IDX_W-1:0] wb_tag;
  logic [WB_CH*XLEN-1:0]  wb_val;
  logic [WB_CH-1:0]       wb_taken;

  logic                   commit_valid;
  logic [IDX_W-1:0]       commit_tag;
  logic [REG_W-1:0]       commit_rd;
  logic [XLEN-1:0]        commit_val;

  logic                   store_req;
  logic [IDX_W-1:0]       store_tag;
  logic                   store_ack;

  logic                   flush;
  logic [XLEN-1:0]        redirect_pc;

  modport master (
    output issue_valid, issue_kind, issue_pc, issue_imm, issue_rd, issue_pred_taken,
    output wb_valid, wb_tag, wb_val, wb_taken, store_ack,
    input  issue_tag, full, count, head_tag,
    input  commit_valid, commit_tag, commit_rd, commit_val,
    input  store_req, store_tag, flush, redirect_pc
  );

  modport slave (
    input  issue_valid, issue_kind, issue_pc, issue_imm, issue_rd, issue_pred_taken,
    input  wb_valid, wb_tag, wb_val, wb_taken, store_ack,
    output issue_tag, full, count, head_tag,
    output commit_valid, commit_tag, commit_rd, commit_val,
    output store_req, store_tag, flush, redirect_pc
  );
endinterface

// File: rtl/rob_multi_wb.sv
// Reorder buffer with N writeback channels, in-order single commit, branch/JALR
// redirect via flush, and a store-commit handshake with the load/store buffer.
module rob_multi_wb #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned IDX_W       = 5,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned WB_CH       = 2,
  parameter int unsigned FULL_MARGIN = 1
) (
  input logic          clk_in,
  input logic          rst_n_in,
  input logic          rdy_in,
  rob_multi_wb_if.slave bus
);

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JALR   = 2'd2,
    KIND_STORE  = 2'd3
  } kind_e;

  localparam int unsigned      CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_AT = CNT_W'(DEPTH - FULL_MARGIN);

  logic [DEPTH-1:0]             valid_q, ready_q, pred_q, taken_q;
  logic [DEPTH-1:0][1:0]        kind_q;
  logic [DEPTH-1:0][XLEN-1:0]   pc_q, imm_q, val_q;
  logic [DEPTH-1:0][REG_W-1:0]  rd_q;
  logic [IDX_W-1:0]             head_q, tail_q;
  logic [CNT_W-1:0]             count_q, count_d;

  logic                         commit_valid_q;
  logic [IDX_W-1:0]             commit_tag_q;
  logic [REG_W-1:0]             commit_rd_q;
  logic [XLEN-1:0]              commit_val_q;
  logic                         flush_q;
  logic [XLEN-1:0]              redirect_q;

  kind_e                        head_kind;
  logic                         head_live, retire, flush_d, issue_acc, full;
  logic [XLEN-1:0]              head_pc4, redirect_d;

  always_comb begin
    head_kind  = kind_e'(kind_q[head_q]);
    head_live  = valid_q[head_q];
    head_pc4   = pc_q[head_q] + XLEN'(4);
    full       = count_q >= FULL_AT;
    issue_acc  = bus.issue_valid && !full;
    retire     = 1'b0;
    flush_d    = 1'b0;
    redirect_d = head_pc4;
    if (head_live) begin
      if (head_kind == KIND_STORE) retire = bus.store_ack;
      else                         retire = ready_q[head_q];
    end
    if (retire) begin
      if (head_kind == KIND_JALR) begin
        flush_d    = 1'b1;
        redirect_d = {val_q[head_q][XLEN-1:1], 1'b0};
      end else if (head_kind == KIND_BRANCH && (taken_q[head_q] != pred_q[head_q])) begin
        flush_d    = 1'b1;
        redirect_d = taken_q[head_q] ? (pc_q[head_q] + imm_q[head_q]) : head_pc4;
      end
    end
    count_d = count_q + CNT_W'(issue_acc) - CNT_W'(retire);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q        <= '0;
      ready_q        <= '0;
      pred_q         <= '0;
      taken_q        <= '0;
      kind_q         <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      val_q          <= '0;
      rd_q           <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      flush_q        <= 1'b0;
      redirect_q     <= '0;
    end else if (!rdy_in) begin
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      commit_valid_q <= 1'b0;
      flush_q        <= flush_d;
      if (flush_d) begin
        // Redirect squashes everything, including this cycle's issue and writebacks.
        valid_q    <= '0;
        ready_q    <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        redirect_q <= redirect_d;
        if (head_kind == KIND_JALR) begin
          commit_valid_q <= 1'b1;
          commit_tag_q   <= head_q;
          commit_rd_q    <= rd_q[head_q];
          commit_val_q   <= head_pc4;
        end
      end else begin
        // Highest channel first so the lowest-index channel's write lands last and wins.
        for (int unsigned c = WB_CH; c > 0; c--) begin
          if (bus.wb_valid[c-1] && valid_q[bus.wb_tag[(c-1)*IDX_W +: IDX_W]]) begin
            ready_q[bus.wb_tag[(c-1)*IDX_W +: IDX_W]] <= 1'b1;
            val_q[bus.wb_tag[(c-1)*IDX_W +: IDX_W]]   <= bus.wb_val[(c-1)*XLEN +: XLEN];
            taken_q[bus.wb_tag[(c-1)*IDX_W +: IDX_W]] <= bus.wb_taken[c-1];
          end
        end
        if (issue_acc) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= (kind_e'(bus.issue_kind) == KIND_STORE);
          kind_q[tail_q]  <= bus.issue_kind;
          pc_q[tail_q]    <= bus.issue_pc;
          imm_q[tail_q]   <= bus.issue_imm;
          rd_q[tail_q]    <= bus.issue_rd;
          pred_q[tail_q]  <= bus.issue_pred_taken;
          tail_q          <= tail_q + IDX_W'(1);
        end
        if (retire) begin
          valid_q[head_q] <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + IDX_W'(1);
          if (head_kind == KIND_REG) begin
            commit_valid_q <= 1'b1;
            commit_tag_q   <= head_q;
            commit_rd_q    <= rd_q[head_q];
            commit_val_q   <= val_q[head_q];
          end
        end
        count_q <= count_d;
      end
    end
  end

  assign bus.issue_tag    = tail_q;
  assign bus.full         = full;
  assign bus.count        = count_q;
  assign bus.head_tag     = head_q;
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_tag   = commit_tag_q;
  assign bus.commit_rd    = commit_rd_q;
  assign bus.commit_val   = commit_val_q;
  assign bus.store_req    = head_live && (head_kind == KIND_STORE);
  assign bus.store_tag    = head_q;
  assign bus.flush        = flush_q;
  assign bus.redirect_pc  = redirect_q;

endmodule

// File: tb/tb_rob_multi_wb.sv
// Bench for rob_multi_wb: directed scenarios then random traffic, all checked
// every cycle against a queue-based reorder-buffer model.
module tb_rob_multi_wb;
  localparam int unsigned DEPTH = 8, IDX_W = 3, XLEN = 32, REG_W = 5, WB_CH = 2, FULL_MARGIN = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;

  rob_multi_wb_if #(.IDX_W(IDX_W), .XLEN(XLEN), .REG_W(REG_W), .WB_CH(WB_CH)) bus ();

  rob_multi_wb #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .REG_W(REG_W),
                 .WB_CH(WB_CH), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] tag;
    int               kind;
    logic [XLEN-1:0]  pc, imm, val;
    logic [REG_W-1:0] rd;
    bit               pred, ready, taken;
  } ent_t;

  ent_t             q[$];
  int unsigned      m_tail;
  bit               e_cv, e_fl;
  logic [IDX_W-1:0] e_ctag;
  logic [REG_W-1:0] e_crd;
  logic [XLEN-1:0]  e_cval, e_redir;
  int               n_total = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0; e_cv = 0; e_fl = 0; e_ctag = '0; e_crd = '0; e_cval = '0; e_redir = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit ret, fl, skip;
    logic [XLEN-1:0] rp;
    logic [WB_CH*IDX_W-1:0] tags;
    logic [WB_CH*XLEN-1:0] vals;
    ent_t h, n;
    e_cv = 0; e_fl = 0;
    if (!rdy) return;
    ret = 0; fl = 0; rp = '0;
    if (q.size() > 0) begin
      h = q[0];
      ret = (h.kind == 3) ? bus.store_ack : h.ready;
      if (ret) begin
        if (h.kind == 0) begin
          e_cv = 1; e_ctag = h.tag; e_crd = h.rd; e_cval = h.val;
        end else if (h.kind == 1 && h.taken != h.pred) begin
          fl = 1; rp = h.taken ? h.pc + h.imm : h.pc + 32'd4;
        end else if (h.kind == 2) begin
          e_cv = 1; e_ctag = h.tag; e_crd = h.rd; e_cval = h.pc + 32'd4;
          fl = 1; rp = h.val & ~32'd1;
        end
      end
    end
    if (fl) begin
      e_fl = 1; e_redir = rp; q.delete(); m_tail = 0;
      return;
    end
    tags = bus.wb_tag; vals = bus.wb_val;
    for (int ch = 0; ch < int'(WB_CH); ch++) begin
      if (!bus.wb_valid[ch]) continue;
      skip = 0;
      for (int p = 0; p < ch; p++)
        if (bus.wb_valid[p] && tags[p*IDX_W +: IDX_W] == tags[ch*IDX_W +: IDX_W]) skip = 1;
      if (skip) continue;
      for (int i = 0; i < q.size(); i++)
        if (q[i].tag == tags[ch*IDX_W +: IDX_W]) begin
          q[i].ready = 1; q[i].val = vals[ch*XLEN +: XLEN]; q[i].taken = bus.wb_taken[ch];
        end
    end
    if (bus.issue_valid && q.size() < int'(DEPTH - FULL_MARGIN)) begin
      n.tag = IDX_W'(m_tail); n.kind = int'(bus.issue_kind); n.pc = bus.issue_pc;
      n.imm = bus.issue_imm; n.rd = bus.issue_rd; n.pred = bus.issue_pred_taken;
      n.ready = (bus.issue_kind == 2'd3); n.val = '0; n.taken = 0;
      q.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (ret) void'(q.pop_front());
  endtask

  task automatic check_outputs();
    bit sr;
    sr = (q.size() > 0) && (q[0].kind == 3);
    check_eq("count", 64'(bus.count), 64'(q.size()));
    check_eq("full", 64'(bus.full), 64'(q.size() >= int'(DEPTH - FULL_MARGIN)));
    check_eq("issue_tag", 64'(bus.issue_tag), 64'(m_tail));
    check_eq("head_tag", 64'(bus.head_tag), 64'((m_tail + DEPTH - q.size()) % DEPTH));
    check_eq("store_req", 64'(bus.store_req), 64'(sr));
    if (sr) check_eq("store_tag", 64'(bus.store_tag), 64'(q[0].tag));
    check_eq("commit_valid", 64'(bus.commit_valid), 64'(e_cv));
    check_eq("commit_tag", 64'(bus.commit_tag), 64'(e_ctag));
    check_eq("commit_rd", 64'(bus.commit_rd), 64'(e_crd));
    check_eq("commit_val", 64'(bus.commit_val), 64'(e_cval));
    check_eq("flush", 64'(bus.flush), 64'(e_fl));
    check_eq("redirect_pc", 64'(bus.redirect_pc), 64'(e_redir));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_count"}, 64'(bus.count), 64'd0);
    check_eq({tag, "_full"}, 64'(bus.full), 64'd0);
    check_eq({tag, "_tags"}, 64'({bus.issue_tag, bus.head_tag, bus.store_tag, bus.commit_tag}), 64'd0);
    check_eq({tag, "_commit"}, 64'({bus.commit_valid, bus.commit_rd}), 64'd0);
    check_eq({tag, "_cval"}, 64'(bus.commit_val), 64'd0);
    check_eq({tag, "_sreq_flush"}, 64'({bus.store_req, bus.flush}), 64'd0);
    check_eq({tag, "_redirect"}, 64'(bus.redirect_pc), 64'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    rdy = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_kind = 2'd0; bus.issue_pc = '0; bus.issue_imm = '0;
    bus.issue_rd = '0; bus.issue_pred_taken = 1'b0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_val = '0; bus.wb_taken = '0;
    bus.store_ack = 1'b0;
  endtask

  task automatic set_issue(input int k, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                           input int rd, input bit pred);
    bus.issue_valid = 1'b1; bus.issue_kind = 2'(k); bus.issue_pc = pc; bus.issue_imm = imm;
    bus.issue_rd = REG_W'(rd); bus.issue_pred_taken = pred;
  endtask

  task automatic set_wb(input int ch, input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] val,
                        input bit taken);
    bus.wb_valid[ch] = 1'b1;
    bus.wb_tag[ch*IDX_W +: IDX_W] = tag;
    bus.wb_val[ch*XLEN +: XLEN] = val;
    bus.wb_taken[ch] = taken;
  endtask

  task automatic rand_in(input int cyc);
    int r, prob;
    logic [IDX_W-1:0] t;
    idle_in();
    rdy = ($urandom_range(0, 9) != 0);
    bus.issue_valid = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 19);
    bus.issue_kind = (r < 11) ? 2'd0 : (r < 14) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
    bus.issue_pc = $urandom; bus.issue_imm = $urandom;
    bus.issue_rd = REG_W'($urandom_range(0, 31)); bus.issue_pred_taken = 1'($urandom_range(0, 1));
    prob = ((cyc / 64) % 2 == 1) ? 60 : 15;
    for (int ch = 0; ch < int'(WB_CH); ch++) begin
      if ($urandom_range(0, 99) < prob) begin
        if (q.size() > 0 && $urandom_range(0, 9) < 8) t = q[$urandom_range(0, q.size() - 1)].tag;
        else t = IDX_W'($urandom_range(0, DEPTH - 1));
        if (ch > 0 && bus.wb_valid[0] && $urandom_range(0, 9) == 0) t = bus.wb_tag[IDX_W-1:0];
        set_wb(ch, t, $urandom, 1'($urandom_range(0, 1)));
      end
    end
    bus.store_ack = ($urandom_range(0, 2) == 0);
  endtask

  logic [IDX_W-1:0] t;

  initial begin
    idle_in();
    rdy = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    idle_in();

    // Three REG entries completed out of order retire in order.
    for (int i = 1; i <= 3; i++) begin set_issue(0, 32'h40 + 32'(4*i), '0, i, 0); step(); idle_in(); end
    set_wb(1, 3'd2, 32'h22, 0); step(); idle_in();
    set_wb(0, 3'd0, 32'h10, 0); step(); idle_in();
    set_wb(1, 3'd1, 32'h11, 0); step(); idle_in();
    step(); step();
    check_eq("ooo_last_val", 64'(bus.commit_val), 64'h22);
    check_eq("ooo_last_rd", 64'(bus.commit_rd), 64'd3);
    step();
    check_eq("ooo_count", 64'(bus.count), 64'd0);

    // JALR: link value and target with bit 0 cleared.
    t = IDX_W'(m_tail);
    set_issue(2, 32'h200, '0, 1, 0); step(); idle_in();
    set_wb(0, t, 32'h305, 0); step(); idle_in();
    step();
    check_eq("jalr_flush", 64'(bus.flush), 64'd1);
    check_eq("jalr_link", 64'(bus.commit_val), 64'h204);
    check_eq("jalr_target", 64'(bus.redirect_pc), 64'h304);
    step();

    // Mispredicted taken branch, then a correctly predicted one.
    t = IDX_W'(m_tail);
    set_issue(1, 32'h100, 32'h20, 0, 0); step(); idle_in();
    set_wb(0, t, '0, 1); step(); idle_in();
    step();
    check_eq("br_flush", 64'(bus.flush), 64'd1);
    check_eq("br_target", 64'(bus.redirect_pc), 64'h120);
    step();
    t = IDX_W'(m_tail);
    set_issue(1, 32'h100, 32'h20, 0, 1); step(); idle_in();
    set_wb(1, t, '0, 1); step(); idle_in();
    step();
    check_eq("br_ok_noflush", 64'(bus.flush), 64'd0);

    // Both channels hit the same tag: channel 0 wins.
    t = IDX_W'(m_tail);
    set_issue(0, 32'h300, '0, 5, 0); step(); idle_in();
    set_wb(0, t, 32'hA, 0); set_wb(1, t, 32'hB, 0); step(); idle_in();
    step();
    check_eq("same_tag_val", 64'(bus.commit_val), 64'hA);

    // Store waits at the head for the acknowledge.
    t = IDX_W'(m_tail);
    set_issue(3, 32'h400, '0, 0, 0); step(); idle_in();
    set_issue(0, 32'h404, '0, 7, 0); step(); idle_in();
    set_wb(0, t + IDX_W'(1), 32'h77, 0); step(); idle_in();
    for (int i = 0; i < 3; i++) begin step(); check_eq("store_hold", 64'(bus.store_req), 64'd1); end
    bus.store_ack = 1'b1; step(); idle_in();
    step();
    check_eq("after_store_rd", 64'(bus.commit_rd), 64'd7);

    // Fill to the margin; the extra issue is dropped; one retire clears full.
    for (int i = 0; i < 8; i++) begin set_issue(0, 32'h500, '0, 9, 0); step(); end
    idle_in();
    check_eq("fill_full", 64'(bus.full), 64'd1);
    check_eq("fill_count", 64'(bus.count), 64'd7);
    set_wb(0, q[0].tag, 32'h55, 0); step(); idle_in();
    step();
    check_eq("drain_full", 64'(bus.full), 64'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_in(cyc);
      step();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        model_reset();
        #1 rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
